hawk_axi_rd_arb: RTL and testbench

- Downstream neighbour of the CPU stall/halt read bridge in the HACD chipset path.
- Arbitrates a single AXI4 read master port to DRAM between two sources: port 0 is the CPU read bridge output, port 1 is the hawk control unit's internal read master (ATT/list fetches).
- Lock-step operation: exactly one read burst is outstanding at any time. Read data is routed back to the port that owns the burst.
- Checks burst-length consistency and reports protocol anomalies.

---
 rtl/hacd_pkg.sv | 54 +++++
 rtl/hawk_axi_rd_arb_beat_chk.sv | 54 +++++
 rtl/hawk_axi_rd_arb.sv | 171 +++++++++++++++++
 tb/tb_hawk_axi_rd_arb.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_pkg.sv
// Shared HACD AXI4 read-path types: AR/R payload structs, read-arbiter state and port ids.
// Field widths come from the `HACD_AXI4_* defines, with defaults supplied here if absent.
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 4
`endif

package hacd_pkg;

  localparam int AXI_ID_W   = `HACD_AXI4_ID_WIDTH;
  localparam int AXI_ADDR_W = `HACD_AXI4_ADDR_WIDTH;
  localparam int AXI_DATA_W = `HACD_AXI4_DATA_WIDTH;
  localparam int AXI_USER_W = `HACD_AXI4_USER_WIDTH;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [3:0]            region;
    logic [AXI_USER_W-1:0] user;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [AXI_USER_W-1:0] user;
  } axi_r_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } rd_arb_state_t;

  localparam logic RD_ARB_CPU  = 1'b0;
  localparam logic RD_ARB_HAWK = 1'b1;

endpackage

// File: rtl/hawk_axi_rd_arb_beat_chk.sv
// Beat counter and burst-length checker for one outstanding burst; flags length
// mismatches and response beats arriving while no burst is in its data phase.
module hawk_rd_beat_chk
  import hacd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ld_len_i,
  input  logic [7:0] len_i,
  input  logic       clr_i,
  input  logic       in_data_i,
  input  logic       vld_i,
  input  logic       hs_i,
  input  logic       last_i,
  output logic       rlast_err_o,
  output logic       spurious_o
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] len_q, len_d;
  logic       rlast_err_q, rlast_err_d;
  logic       spur_q, spur_d;

  always_comb begin
    len_d = ld_len_i ? len_i : len_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hs_i) begin
      cnt_d = cnt_q + 8'd1;
    end
    // A beat is wrong if its last flag disagrees with its position against len.
    rlast_err_d = hs_i & (last_i ? (cnt_q != len_q) : (cnt_q == len_q));
    spur_d      = vld_i & ~in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      len_q       <= '0;
      rlast_err_q <= 1'b0;
      spur_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      rlast_err_q <= rlast_err_d;
      spur_q      <= spur_d;
    end
  end

  assign rlast_err_o = rlast_err_q;
  assign spurious_o  = spur_q;

endmodule

// File: rtl/hawk_axi_rd_arb.sv
// Two-port AXI4 read arbiter (CPU bridge / hawk internal master) with one burst in flight.
// Optional stall watchdog enabled by defining HACD_RD_ARB_WDOG_EN.
module hawk_axi_rd_arb
  import hacd_pkg::*;
#(
  parameter int ID_WIDTH    = `HACD_AXI4_ID_WIDTH,
  parameter int ADDR_WIDTH  = `HACD_AXI4_ADDR_WIDTH,
  parameter int DATA_WIDTH  = `HACD_AXI4_DATA_WIDTH,
  parameter int USER_WIDTH  = `HACD_AXI4_USER_WIDTH,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic    clk,
  input  logic    rst_n,
  input  axi_ar_t cpu_ar,
  input  logic    cpu_arvalid,
  output logic    cpu_arready,
  input  axi_ar_t hawk_ar,
  input  logic    hawk_arvalid,
  output logic    hawk_arready,
  output axi_r_t  cpu_r,
  output logic    cpu_rvalid,
  input  logic    cpu_rready,
  output axi_r_t  hawk_r,
  output logic    hawk_rvalid,
  input  logic    hawk_rready,
  output axi_ar_t m_ar,
  output logic    m_arvalid,
  input  logic    m_arready,
  input  axi_r_t  m_r,
  input  logic    m_rvalid,
  output logic    m_rready,
  output logic    owner,
  output logic    busy,
  output logic    rlast_err,
  output logic    spurious_r,
  output logic    wdog_err
);

  rd_arb_state_t state_q, state_d;
  logic          owner_q, owner_d;
  axi_ar_t       m_ar_q, m_ar_d;

  logic          idle, in_data, grant_hawk, ar_hs, m_ar_hs, r_hs;
  axi_ar_t       sel_ar;
  axi_r_t        r_fwd;
  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [USER_WIDTH-1:0] sel_user;
  logic [DATA_WIDTH-1:0] r_data;

  assign idle       = (state_q == IDLE);
  assign in_data    = (state_q == DATA);
  // Hawk has fixed priority: the CPU is typically stalled waiting on hawk's fetch.
  assign grant_hawk = hawk_arvalid;
  assign ar_hs      = idle & (hawk_arvalid | cpu_arvalid);

  assign hawk_arready = idle & hawk_arvalid;
  assign cpu_arready  = idle & ~hawk_arvalid & cpu_arvalid;

  assign sel_ar   = grant_hawk ? hawk_ar : cpu_ar;
  assign sel_id   = sel_ar.id;
  assign sel_addr = sel_ar.addr;
  assign sel_user = sel_ar.user;
  assign r_data   = m_r.data;

  // Payloads are assembled field by field so parameter/define width drift shows up as a width error.
  always_comb begin
    m_ar_d        = sel_ar;
    m_ar_d.id     = sel_id;
    m_ar_d.addr   = sel_addr;
    m_ar_d.user   = sel_user;
    r_fwd         = m_r;
    r_fwd.data    = r_data;
  end

  assign m_arvalid = (state_q == ADDR);
  assign m_ar_hs   = m_arvalid & m_arready;
  assign m_rready  = in_data & ((owner_q == RD_ARB_HAWK) ? hawk_rready : cpu_rready);
  assign r_hs      = m_rvalid & m_rready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d = ADDR;
          owner_d = grant_hawk ? RD_ARB_HAWK : RD_ARB_CPU;
        end
      end
      ADDR: begin
        if (m_arready) state_d = DATA;
      end
      DATA: begin
        // Only the last flag ends a burst; length errors are reported, not enforced.
        if (r_hs && m_r.last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= RD_ARB_CPU;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) m_ar_q <= m_ar_d;
  end

  assign m_ar        = m_ar_q;
  assign cpu_r       = r_fwd;
  assign hawk_r      = r_fwd;
  assign cpu_rvalid  = in_data & (owner_q == RD_ARB_CPU) & m_rvalid;
  assign hawk_rvalid = in_data & (owner_q == RD_ARB_HAWK) & m_rvalid;
  assign owner       = owner_q;
  assign busy        = ~idle;

  hawk_rd_beat_chk u_beat_chk (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ld_len_i    (ar_hs),
    .len_i       (m_ar_d.len),
    .clr_i       (m_ar_hs),
    .in_data_i   (in_data),
    .vld_i       (m_rvalid),
    .hs_i        (r_hs),
    .last_i      (m_r.last),
    .rlast_err_o (rlast_err),
    .spurious_o  (spurious_r)
  );

`ifdef HACD_RD_ARB_WDOG_EN
  localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        wdog_err_q, wdog_err_d, stall;

  assign stall = busy & ~(m_ar_hs | r_hs);

  always_comb begin
    wdog_d     = '0;
    wdog_err_d = 1'b0;
    if (stall) begin
      wdog_d     = (wdog_q == WDOG_LIM) ? wdog_q : wdog_q + 16'd1;
      // Fires once on the step into the limit; the saturated counter cannot re-fire.
      wdog_err_d = (wdog_q == WDOG_LIM - 16'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_hawk_axi_rd_arb.sv
// Randomized bench for hawk_axi_rd_arb: burst-level reference model plus directed scenarios.
module tb_hawk_axi_rd_arb;
  import hacd_pkg::*;

  localparam int WDOG = 8;

  logic    clk = 1'b0;
  logic    rst_n;
  axi_ar_t cpu_ar, hawk_ar, m_ar;
  logic    cpu_arvalid, cpu_arready, hawk_arvalid, hawk_arready;
  axi_r_t  cpu_r, hawk_r, m_r;
  logic    cpu_rvalid, cpu_rready, hawk_rvalid, hawk_rready;
  logic    m_arvalid, m_arready, m_rvalid, m_rready;
  logic    owner, busy, rlast_err, spurious_r, wdog_err;

  int checks = 0;
  int failures = 0;

  // slave knobs: ar_mode 0 random / 1 always ready / 2 never ready; inj_mode 0 ok / 1 early last / 2 late last
  int ar_mode = 1;
  int inj_mode = 0;
  int spur_left = 0;

  hawk_axi_rd_arb #(.WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ar(cpu_ar), .cpu_arvalid(cpu_arvalid), .cpu_arready(cpu_arready),
    .hawk_ar(hawk_ar), .hawk_arvalid(hawk_arvalid), .hawk_arready(hawk_arready),
    .cpu_r(cpu_r), .cpu_rvalid(cpu_rvalid), .cpu_rready(cpu_rready),
    .hawk_r(hawk_r), .hawk_rvalid(hawk_rvalid), .hawk_rready(hawk_rready),
    .m_ar(m_ar), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_r(m_r), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .owner(owner), .busy(busy), .rlast_err(rlast_err), .spurious_r(spurious_r),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic axi_ar_t rand_ar();
    axi_ar_t a;
    a.id     = AXI_ID_W'($urandom);
    a.addr   = AXI_ADDR_W'($urandom);
    a.len    = 8'($urandom_range(0, 7));
    a.size   = 3'($urandom);
    a.burst  = 2'($urandom);
    a.lock   = 1'($urandom);
    a.cache  = 4'($urandom);
    a.prot   = 3'($urandom);
    a.qos    = 4'($urandom);
    a.region = 4'($urandom);
    a.user   = AXI_USER_W'($urandom);
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- downstream slave ----------------
  initial begin : slave
    bit   s_active = 0, r_hold = 0;
    int   s_len = 0, s_beat = 0, s_mode = 0;
    logic [AXI_ID_W-1:0] s_id = '0;
    logic last_b;
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_r       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_active = 0;
        r_hold   = 0;
      end else begin
        if (m_rvalid && m_rready) begin
          r_hold = 0;
          s_beat++;
          if (m_r.last) s_active = 0;
        end
        if (m_arvalid && m_arready) begin
          s_active = 1;
          s_len    = int'(m_ar.len);
          s_beat   = 0;
          s_id     = m_ar.id;
          s_mode   = inj_mode;
        end
      end
      @(posedge clk);
      #1;
      m_arready = (ar_mode == 1) ? 1'b1 : (ar_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (spur_left > 0) begin
        m_r      = '0;
        m_r.data = AXI_DATA_W'({$urandom, $urandom});
        m_r.last = 1'($urandom);
        m_rvalid = 1'b1;
        spur_left--;
      end else if (s_active) begin
        if (!r_hold) begin
          if ($urandom_range(0, 3) != 0) begin
            if (s_mode == 1 && s_len > 0) last_b = (s_beat == s_len - 1);
            else if (s_mode == 2)         last_b = (s_beat == s_len + 1);
            else                          last_b = (s_beat == s_len);
            m_r.id   = s_id;
            m_r.data = AXI_DATA_W'({$urandom, $urandom});
            m_r.resp = 2'($urandom);
            m_r.last = last_b;
            m_r.user = AXI_USER_W'($urandom);
            m_rvalid = 1'b1;
            r_hold   = 1;
          end else begin
            m_rvalid = 1'b0;
          end
        end
      end else begin
        m_rvalid = 1'b0;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  initial begin : model
    bit pend = 0, open = 0, own = 0, e_rl = 0, e_sp = 0;
    int beats = 0, run = 0;
    axi_ar_t ar_m = '0;
    bit idle, e_rready, rhs, e_wd, hs, nrl, nsp, was_pend;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 0; open = 0; own = 0; e_rl = 0; e_sp = 0; beats = 0; run = 0;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_rlast_err", rlast_err, 0);
        chk("rst_spurious_r", spurious_r, 0);
        chk("rst_wdog_err", wdog_err, 0);
      end else begin
        idle     = !pend && !open;
        e_rready = open && (own ? hawk_rready : cpu_rready);
        rhs      = e_rready && m_rvalid;
`ifdef HACD_RD_ARB_WDOG_EN
        e_wd = (run == WDOG - 1);
`else
        e_wd = 0;
`endif
        chk("busy", busy, !idle);
        chk("owner", owner, own);
        chk("m_arvalid", m_arvalid, pend);
        chk("hawk_arready", hawk_arready, idle && hawk_arvalid);
        chk("cpu_arready", cpu_arready, idle && !hawk_arvalid && cpu_arvalid);
        chk("m_rready", m_rready, e_rready);
        chk("cpu_rvalid", cpu_rvalid, open && !own && m_rvalid);
        chk("hawk_rvalid", hawk_rvalid, open && own && m_rvalid);
        chk("rlast_err", rlast_err, e_rl);
        chk("spurious_r", spurious_r, e_sp);
        chk("wdog_err", wdog_err, e_wd);
        if (pend) chk("m_ar", m_ar, ar_m);
        if (open && !own && m_rvalid) chk("cpu_r", cpu_r, m_r);
        if (open && own && m_rvalid)  chk("hawk_r", hawk_r, m_r);
        // advance model by one clock
        was_pend = pend;
        hs  = (pend && m_arready) || rhs;
        nsp = m_rvalid && !open;
        nrl = 0;
        if (idle && (hawk_arvalid || cpu_arvalid)) begin
          pend = 1;
          own  = hawk_arvalid;
          ar_m = hawk_arvalid ? hawk_ar : cpu_ar;
        end else if (was_pend && m_arready) begin
          pend  = 0;
          open  = 1;
          beats = 0;
        end else if (rhs) begin
          nrl = m_r.last ? (beats != int'(ar_m.len)) : (beats == int'(ar_m.len));
          beats++;
          if (m_r.last) open = 0;
        end
        run  = (!idle && !hs) ? run + 1 : 0;
        e_rl = nrl;
        e_sp = nsp;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic run_burst(input int max_cyc, output int nc, output int nh, output int last_at,
                           output int n_rl, output int n_sp);
    bit done = 0;
    nc = 0; nh = 0; last_at = -1; n_rl = 0; n_sp = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (rlast_err) n_rl++;
      if (spurious_r) n_sp++;
      if (cpu_rvalid && cpu_rready) begin
        if (cpu_r.last) last_at = nc;
        nc++;
      end
      if (hawk_rvalid && hawk_rready) begin
        if (hawk_r.last) last_at = nh;
        nh++;
      end
      if (!busy) begin
        done = 1;
        break;
      end
    end
    chk("burst_completes", done, 1);
    repeat (2) begin
      @(negedge clk);
      if (rlast_err) n_rl++;
      if (spurious_r) n_sp++;
    end
  endtask

  initial begin : stim
    int nc, nh, last_at, n_rl, n_sp, cnt, first;
    bit hawk_seen, acc_c, acc_h, done;
    rst_n = 1'b0;
    cpu_ar = '0; hawk_ar = '0;
    cpu_arvalid = 0; hawk_arvalid = 0;
    cpu_rready = 1; hawk_rready = 1;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy_lit", busy, 0);
    chk("reset_owner_lit", owner, 0);

    // CPU-only burst
    step();
    cpu_ar = rand_ar(); cpu_ar.addr = 32'h8000_1000; cpu_ar.len = 8'd3;
    cpu_arvalid = 1;
    step();
    cpu_arvalid = 0;
    @(negedge clk);
    chk("cpu_m_arvalid_lat1", m_arvalid, 1);
    chk("cpu_m_ar_addr", m_ar.addr, 32'h8000_1000);
    hawk_seen = 0;
    run_burst(200, nc, nh, last_at, n_rl, n_sp);
    chk("cpu_beats", nc, 4);
    chk("cpu_last_at", last_at, 3);
    chk("cpu_hawk_beats", nh, 0);
    chk("cpu_rlast_err_cnt", n_rl, 0);

    // Simultaneous requests: hawk first
    step();
    cpu_ar = rand_ar(); cpu_ar.len = 8'd1;
    hawk_ar = rand_ar(); hawk_ar.addr = 32'h0000_4000; hawk_ar.len = 8'd2;
    cpu_arvalid = 1; hawk_arvalid = 1;
    @(negedge clk);
    chk("sim_hawk_arready", hawk_arready, 1);
    chk("sim_cpu_arready", cpu_arready, 0);
    step();
    hawk_arvalid = 0;
    @(negedge clk);
    chk("sim_owner_hawk", owner, 1);
    nh = 0; done = 0;
    for (int i = 0; i < 200; i++) begin
      if (hawk_rvalid && hawk_rready) nh++;
      if (cpu_arready) begin done = 1; break; end
      @(negedge clk);
    end
    chk("sim_cpu_granted", done, 1);
    chk("sim_cpu_wait_idle", busy, 0);
    chk("sim_hawk_beats", nh, 3);
    step();
    cpu_arvalid = 0;
    run_burst(200, nc, nh, last_at, n_rl, n_sp);
    chk("sim_cpu_beats", nc, 2);
    chk("sim_owner_cpu", owner, 0);

    // Backpressure
    ar_mode = 2;
    step();
    hawk_ar = rand_ar(); hawk_ar.addr = 32'h0000_4000; hawk_ar.len = 8'd3;
    hawk_arvalid = 1;
    step();
    hawk_arvalid = 0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_arvalid", m_arvalid, 1);
      chk("bp_m_ar_addr", m_ar.addr, 32'h0000_4000);
      chk("bp_m_ar_len", m_ar.len, 3);
    end
    ar_mode = 1;
    nh = 0; done = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      hawk_rready = ~hawk_rready;
      @(negedge clk);
      if (hawk_rvalid && hawk_rready) nh++;
      if (!busy) begin done = 1; break; end
    end
    hawk_rready = 1;
    chk("bp_done", done, 1);
    chk("bp_hawk_beats", nh, 4);

    // Length mismatch: early last
    inj_mode = 1;
    step();
    cpu_ar = rand_ar(); cpu_ar.len = 8'd1;
    cpu_arvalid = 1;
    step();
    cpu_arvalid = 0;
    run_burst(200, nc, nh, last_at, n_rl, n_sp);
    inj_mode = 0;
    chk("mis_beats", nc, 1);
    chk("mis_rlast_err_pulses", n_rl, 1);
    chk("mis_idle", busy, 0);

    // Spurious data in IDLE
    @(negedge clk);
    spur_left = 2;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (spurious_r) cnt++;
      chk("spur_m_rready", m_rready, 0);
    end
    chk("spur_pulses", cnt, 2);

    // Stall watchdog on AR
    ar_mode = 2;
    step();
    hawk_ar = rand_ar(); hawk_ar.len = 8'd0;
    hawk_arvalid = 1;
    step();
    hawk_arvalid = 0;
    cnt = 0; first = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (wdog_err) begin
        if (first == 0) first = i;
        cnt++;
      end
    end
    ar_mode = 1;
`ifdef HACD_RD_ARB_WDOG_EN
    chk("wdog_first_cycle", first, WDOG);
    chk("wdog_pulses", cnt, 1);
`else
    chk("wdog_pulses_off", cnt, 0);
`endif
    run_burst(200, nc, nh, last_at, n_rl, n_sp);

    // Asynchronous reset mid-DATA
    cpu_rready = 0;
    step();
    cpu_ar = rand_ar(); cpu_ar.len = 8'd7;
    cpu_arvalid = 1;
    step();
    cpu_arvalid = 0;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy && !m_arvalid && m_rvalid) begin done = 1; break; end
    end
    chk("rst_reached_data", done, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_m_arvalid", m_arvalid, 0);
    chk("async_rst_cpu_rvalid", cpu_rvalid, 0);
    repeat (2) step();
    rst_n = 1'b1;
    cpu_rready = 1;
    repeat (3) step();

    // Randomized traffic
    ar_mode = 0;
    acc_c = 0; acc_h = 0;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      acc_c = cpu_arvalid && cpu_arready;
      acc_h = hawk_arvalid && hawk_arready;
      @(posedge clk);
      #1;
      if (acc_c) cpu_arvalid = 0;
      if (acc_h) hawk_arvalid = 0;
      if (!cpu_arvalid && $urandom_range(0, 5) == 0) begin
        cpu_ar = rand_ar(); cpu_arvalid = 1;
      end
      if (!hawk_arvalid && $urandom_range(0, 7) == 0) begin
        hawk_ar = rand_ar(); hawk_arvalid = 1;
      end
      cpu_rready  = ($urandom_range(0, 3) != 0);
      hawk_rready = ($urandom_range(0, 3) != 0);
      first = $urandom_range(0, 9);
      inj_mode = (first < 8) ? 0 : (first == 8) ? 1 : 2;
    end

    // Drain
    inj_mode = 0;
    done = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      acc_c = cpu_arvalid && cpu_arready;
      acc_h = hawk_arvalid && hawk_arready;
      if (!busy && !cpu_arvalid && !hawk_arvalid) begin done = 1; break; end
      @(posedge clk);
      #1;
      if (acc_c) cpu_arvalid = 0;
      if (acc_h) hawk_arvalid = 0;
      cpu_rready = 1; hawk_rready = 1;
    end
    chk("drain_idle", done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_bound
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
